// File: rtl/decode_pipe.sv
// RV32I(+optional M) decode stage: one output register plus one skid entry, with
// a decode-time JAL redirect to fetch and a short squash window for wrong-path fetches.
module decode_pipe #(
    parameter int ADDRESS_BITS = 16,
    parameter int ENABLE_M     = 0,
    parameter int SQUASH_SLOTS = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDRESS_BITS-1:0] PC,
    input  logic [31:0]             instruction,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRESS_BITS-1:0] out_PC,
    output logic [4:0]              read_sel1,
    output logic [4:0]              read_sel2,
    output logic [4:0]              write_sel,
    output logic [31:0]             imm32,
    output logic [5:0]              ALU_Control,
    output logic [1:0]              op_A_sel,
    output logic                    op_B_sel,
    output logic                    branch_op,
    output logic                    wEn,
    output logic                    mem_wEn,
    output logic                    wb_sel,
    output logic                    illegal,
    output logic                    next_PC_select,
    output logic [ADDRESS_BITS-1:0] target_PC
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [1:0] SLOTS     = 2'(SQUASH_SLOTS);

    typedef struct packed {
        logic [ADDRESS_BITS-1:0] pc;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [4:0]              rd;
        logic [31:0]             imm;
        logic [5:0]              alu;
        logic [1:0]              opa;
        logic                    opb;
        logic                    br;
        logic                    wen;
        logic                    mwen;
        logic                    wbsel;
        logic                    ill;
        logic                    is_jal;
        logic [ADDRESS_BITS-1:0] target;
    } bundle_t;

    typedef enum logic {RUN, SQUASH} state_t;

    function automatic bundle_t decode(input logic [ADDRESS_BITS-1:0] pc, input logic [31:0] ins);
        bundle_t     b;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        b     = '0;
        f7    = ins[31:25];
        f3    = ins[14:12];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_u = {ins[31:12], 12'b0};
        imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        b.pc     = pc;
        b.rs1    = ins[19:15];
        b.rs2    = ins[24:20];
        b.rd     = ins[11:7];
        b.target = pc + imm_j[ADDRESS_BITS-1:0];
        case (ins[6:0])
            OP_R: begin
                b.opb = 1'b1;
                b.wen = 1'b1;
                if (ENABLE_M != 0 && f7 == 7'b0000001) begin
                    b.alu = {3'b100, f3};
                end else begin
                    b.alu = {2'b00, f7[5], f3};
                    b.ill = !(f7 == 7'b0000000 || f7 == 7'b0100000);
                end
            end
            OP_IMM: begin
                b.imm = imm_i;
                b.alu = {2'b00, f7[5] & (f3 == 3'b101), f3};
                b.wen = 1'b1;
                // Shift-immediates reuse funct7 as an encoding field.
                if (f3 == 3'b001)
                    b.ill = (f7 != 7'b0000000);
                else if (f3 == 3'b101)
                    b.ill = !(f7 == 7'b0000000 || f7 == 7'b0100000);
            end
            OP_LOAD:   begin b.imm = imm_i; b.wen = 1'b1; b.wbsel = 1'b1; end
            OP_STORE:  begin b.imm = imm_s; b.mwen = 1'b1; end
            OP_BRANCH: begin b.imm = imm_b; b.alu = {3'b010, f3}; b.opb = 1'b1; b.br = 1'b1; end
            OP_JAL: begin
                b.imm = imm_j; b.alu = 6'b011111; b.opa = 2'b10;
                b.wen = 1'b1; b.br = 1'b1; b.is_jal = 1'b1;
            end
            OP_JALR:   begin b.imm = imm_i; b.alu = 6'b111111; b.opa = 2'b10; b.wen = 1'b1; b.br = 1'b1; end
            OP_AUIPC:  begin b.imm = imm_u; b.opa = 2'b01; b.wen = 1'b1; end
            OP_LUI:    begin b.imm = imm_u; b.opa = 2'b11; b.wen = 1'b1; end
            default:   b.ill = 1'b1;
        endcase
        if (b.ill) begin
            b.wen  = 1'b0;
            b.mwen = 1'b0;
            b.br   = 1'b0;
        end
        return b;
    endfunction

    bundle_t                 out_reg, decoded;
    logic                    out_valid_reg, first_reg;
    logic                    skid_valid_reg;
    logic [ADDRESS_BITS-1:0] skid_pc_reg;
    logic [31:0]             skid_instr_reg;
    state_t                  state_reg, state_next;
    logic [1:0]              count_reg, count_next;
    logic                    in_accept, out_free, redirect, skid_live, keep_input, load_out;

    assign in_ready   = reset & ~flush & ~skid_valid_reg;
    assign in_accept  = in_valid & in_ready;
    assign out_free   = ~out_valid_reg | out_ready;
    assign redirect   = reset & ~flush & out_valid_reg & first_reg & out_reg.is_jal;
    // A skid entry sitting behind a redirecting JAL is wrong-path.
    assign skid_live  = skid_valid_reg & ~redirect;
    assign keep_input = in_accept & (state_reg == RUN);
    assign load_out   = out_free & (skid_live | keep_input);
    assign decoded    = skid_live ? decode(skid_pc_reg, skid_instr_reg) : decode(PC, instruction);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        if (redirect) begin
            count_next = skid_valid_reg ? SLOTS - 2'd1 : SLOTS;
            state_next = (count_next == 2'd0) ? RUN : SQUASH;
        end else if (state_reg == SQUASH && in_accept) begin
            count_next = count_reg - 2'd1;
            if (count_reg == 2'd1)
                state_next = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            state_reg <= RUN;
            count_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_reg        <= '0;
            out_valid_reg  <= 1'b0;
            first_reg      <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_pc_reg    <= '0;
            skid_instr_reg <= '0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
            first_reg      <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            if (out_free) begin
                out_valid_reg <= load_out;
                first_reg     <= load_out;
                if (load_out)
                    out_reg <= decoded;
            end else begin
                first_reg <= 1'b0;
            end
            skid_valid_reg <= ~out_free & (skid_live | keep_input);
            if (keep_input) begin
                skid_pc_reg    <= PC;
                skid_instr_reg <= instruction;
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_PC         = out_reg.pc;
    assign read_sel1      = out_reg.rs1;
    assign read_sel2      = out_reg.rs2;
    assign write_sel      = out_reg.rd;
    assign imm32          = out_reg.imm;
    assign ALU_Control    = out_reg.alu;
    assign op_A_sel       = out_reg.opa;
    assign op_B_sel       = out_reg.opb;
    assign branch_op      = out_reg.br;
    assign wEn            = out_reg.wen;
    assign mem_wEn        = out_reg.mwen;
    assign wb_sel         = out_reg.wbsel;
    assign illegal        = out_reg.ill;
    assign next_PC_select = redirect;
    assign target_PC      = out_reg.target;

endmodule

// File: tb/tb_decode_pipe.sv
// Randomized + directed bench for decode_pipe: a queue-based flow model feeds a
// scoreboard that a negedge monitor compares against two instances (M off / M on).
module tb_decode_pipe;

    logic        clock = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    logic [15:0] PC;
    logic [31:0] instruction;

    logic        rdy0, vld0, nps0, opb0, br0, wen0, mwen0, wbs0, ill0;
    logic        rdy1, vld1, nps1, opb1, br1, wen1, mwen1, wbs1, ill1;
    logic [15:0] pc0, tgt0, pc1, tgt1;
    logic [4:0]  rs1_0, rs2_0, rd0, rs1_1, rs2_1, rd1;
    logic [31:0] imm0, imm1;
    logic [5:0]  alu0, alu1;
    logic [1:0]  opa0, opa1;

    decode_pipe #(.ADDRESS_BITS(16), .ENABLE_M(0), .SQUASH_SLOTS(1)) u_dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .PC(PC),
        .instruction(instruction), .flush(flush), .out_valid(vld0), .out_ready(out_ready),
        .out_PC(pc0), .read_sel1(rs1_0), .read_sel2(rs2_0), .write_sel(rd0), .imm32(imm0),
        .ALU_Control(alu0), .op_A_sel(opa0), .op_B_sel(opb0), .branch_op(br0), .wEn(wen0),
        .mem_wEn(mwen0), .wb_sel(wbs0), .illegal(ill0), .next_PC_select(nps0), .target_PC(tgt0));

    decode_pipe #(.ADDRESS_BITS(16), .ENABLE_M(1), .SQUASH_SLOTS(1)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .PC(PC),
        .instruction(instruction), .flush(flush), .out_valid(vld1), .out_ready(out_ready),
        .out_PC(pc1), .read_sel1(rs1_1), .read_sel2(rs2_1), .write_sel(rd1), .imm32(imm1),
        .ALU_Control(alu1), .op_A_sel(opa1), .op_B_sel(opb1), .branch_op(br1), .wEn(wen1),
        .mem_wEn(mwen1), .wb_sel(wbs1), .illegal(ill1), .next_PC_select(nps1), .target_PC(tgt1));

    initial forever #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [5:0]  alu;
        logic [1:0]  opa;
        logic        opb, br, wen, mwen, wbsel, ill;
    } bundle_t;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] ins;
    } item_t;

    bundle_t b0, b1;
    assign b0 = {pc0, rs1_0, rs2_0, rd0, imm0, alu0, opa0, opb0, br0, wen0, mwen0, wbs0, ill0};
    assign b1 = {pc1, rs1_1, rs2_1, rd1, imm1, alu1, opa1, opb1, br1, wen1, mwen1, wbs1, ill1};

    int    checks = 0;
    int    errors = 0;
    item_t q[$];
    int    squash_cnt = 0;
    bit    fresh = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decode written from the ISA tables: pick the immediate format, then the controls.
    function automatic bundle_t ref_decode(input logic [15:0] pc, input logic [31:0] ins, input bit m);
        bundle_t     b;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] ii, is, ib, iu, ij;
        bit          r_ok;
        b  = '0;
        op = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12];
        ii = 32'($signed(ins[31:20]));
        is = 32'($signed({ins[31:25], ins[11:7]}));
        ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        iu = ins & 32'hFFFFF000;
        ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        b.pc = pc; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
        case (op)
            7'h33: begin
                r_ok = (f7 == 7'h00) || (f7 == 7'h20) || (m && f7 == 7'h01);
                b.alu = (m && f7 == 7'h01) ? {3'b100, f3} : {2'b00, f7[5], f3};
                b.opb = 1; b.wen = 1; b.ill = !r_ok;
            end
            7'h13: begin
                b.imm = ii; b.wen = 1;
                b.alu = {2'b00, (f3 == 3'd5) ? f7[5] : 1'b0, f3};
                if (f3 == 3'd1 && f7 != 7'h00) b.ill = 1;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) b.ill = 1;
            end
            7'h03: begin b.imm = ii; b.wen = 1; b.wbsel = 1; end
            7'h23: begin b.imm = is; b.mwen = 1; end
            7'h63: begin b.imm = ib; b.alu = {3'b010, f3}; b.opb = 1; b.br = 1; end
            7'h6F: begin b.imm = ij; b.alu = 6'd31; b.opa = 2; b.wen = 1; b.br = 1; end
            7'h67: begin b.imm = ii; b.alu = 6'd63; b.opa = 2; b.wen = 1; b.br = 1; end
            7'h17: begin b.imm = iu; b.opa = 1; b.wen = 1; end
            7'h37: begin b.imm = iu; b.opa = 3; b.wen = 1; end
            default: b.ill = 1;
        endcase
        if (b.ill) begin b.wen = 0; b.mwen = 0; b.br = 0; end
        return b;
    endfunction

    function automatic logic [15:0] ref_target(input logic [15:0] pc, input logic [31:0] ins);
        logic [31:0] ij, sum;
        ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        sum = {16'h0, pc} + ij;
        return sum[15:0];
    endfunction

    function automatic bit exp_redirect();
        return reset && !flush && fresh && q.size() > 0 && q[0].ins[6:0] == 7'h6F;
    endfunction

    // Flow model: q[0] is what the output shows, q[1] is what waits behind it.
    initial forever begin : model
        int old_size, ns;
        bit redir, acc, oacc;
        @(posedge clock);
        if (!reset || flush) begin
            q.delete(); squash_cnt = 0; fresh = 0;
        end else begin
            old_size = q.size();
            redir = exp_redirect();
            acc   = in_valid && old_size < 2;
            oacc  = old_size > 0 && out_ready;
            ns    = 1;
            if (redir && old_size == 2) begin q.delete(1); ns = 0; end
            if (oacc) void'(q.pop_front());
            if (acc) begin
                if (squash_cnt > 0) squash_cnt--;
                else q.push_back('{pc: PC, ins: instruction});
            end
            if (redir) squash_cnt = ns;
            fresh = q.size() > 0 && (old_size == 0 || oacc);
        end
    end

    initial forever begin : monitor
        bit er, ev;
        @(negedge clock);
        er = exp_redirect();
        ev = q.size() > 0;
        check("in_ready0", rdy0, reset && !flush && q.size() < 2);
        check("in_ready1", rdy1, reset && !flush && q.size() < 2);
        check("out_valid0", vld0, ev);
        check("out_valid1", vld1, ev);
        check("redirect0", nps0, er);
        check("redirect1", nps1, er);
        if (er) begin
            check("target0", tgt0, ref_target(q[0].pc, q[0].ins));
            check("target1", tgt1, ref_target(q[0].pc, q[0].ins));
        end
        if (ev) begin
            check("bundle_m0", b0, ref_decode(q[0].pc, q[0].ins, 0));
            check("bundle_m1", b1, ref_decode(q[0].pc, q[0].ins, 1));
            if (out_ready)
                $display("txn t=%0t pc=%h instr=%h alu=%h imm=%h ill=%0d", $time, pc0, q[0].ins, alu0, imm0, ill0);
        end
    end

    task automatic drive(input bit iv, input logic [15:0] p, input logic [31:0] ins,
                         input bit ordy, input bit fl, input bit rst, output bit acc);
        in_valid = iv; PC = p; instruction = ins; out_ready = ordy; flush = fl; reset = rst;
        @(negedge clock);
        acc = in_valid && rdy0;
        @(posedge clock);
        #1;
    endtask

    task automatic realign();
        @(posedge clock);
        #1;
    endtask

    localparam logic [31:0] ADDI = 32'hFFF00093;
    localparam logic [31:0] JAL8 = 32'h008000EF;
    localparam logic [31:0] MUL  = 32'h022081B3;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] LW   = 32'h0040A283;
    localparam logic [31:0] SW   = 32'h0020A423;

    initial begin : stim
        bit          acc, have;
        logic [15:0] cpc;
        logic [31:0] cins;
        logic [6:0]  ops [9];
        logic [6:0]  f7;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h17, 7'h37};
        reset = 0; in_valid = 0; flush = 0; out_ready = 0; PC = 0; instruction = 0;
        repeat (3) drive(0, 0, 0, 0, 0, 0, acc);
        @(negedge clock);
        check("reset_bundle", b0, '0);
        check("reset_nps", nps0, 1'b0);
        realign();
        drive(0, 0, 0, 1, 0, 1, acc);

        // ADDI x1,x0,-1
        drive(1, 16'h0010, ADDI, 1, 0, 1, acc);
        in_valid = 0;
        @(negedge clock);
        check("addi_valid", vld0, 1'b1);
        check("addi_imm", imm0, 32'hFFFFFFFF);
        check("addi_alu", alu0, 6'b000000);
        check("addi_wen", wen0, 1'b1);
        check("addi_ill", ill0, 1'b0);
        realign();

        // Back-pressure: two held, third refused, then released in order
        drive(1, 16'h0020, ADD, 0, 0, 1, acc);
        drive(1, 16'h0024, LW, 0, 0, 1, acc);
        drive(1, 16'h0028, SW, 0, 0, 1, acc);
        check("third_refused", acc, 1'b0);
        acc = 0;
        for (int i = 0; i < 5 && !acc; i++) drive(1, 16'h0028, SW, 1, 0, 1, acc);
        check("third_taken", acc, 1'b1);
        repeat (4) drive(0, 0, 0, 1, 0, 1, acc);

        // JAL x1,+8 at 0xFFFC wraps; one following input squashed
        drive(1, 16'hFFFC, JAL8, 1, 0, 1, acc);
        in_valid = 0;
        @(negedge clock);
        check("jal_nps", nps0, 1'b1);
        check("jal_target", tgt0, 16'h0004);
        realign();
        drive(1, 16'h0100, ADD, 1, 0, 1, acc);
        drive(1, 16'h0004, LW, 1, 0, 1, acc);
        repeat (3) drive(0, 0, 0, 1, 0, 1, acc);

        // Flush with output and skid full, JAL waiting in skid
        drive(1, 16'h0040, ADD, 0, 0, 1, acc);
        drive(1, 16'h0044, JAL8, 0, 0, 1, acc);
        drive(1, 16'h0048, LW, 0, 1, 1, acc);
        in_valid = 0; flush = 0; out_ready = 1;
        @(negedge clock);
        check("flush_valid", vld0, 1'b0);
        check("flush_nps", nps0, 1'b0);
        realign();

        // Flush in the same cycle as a JAL redirect
        drive(1, 16'h0050, JAL8, 1, 0, 1, acc);
        drive(0, 0, 0, 1, 1, 1, acc);
        repeat (2) drive(0, 0, 0, 1, 0, 1, acc);

        // MUL with M disabled / enabled
        drive(1, 16'h0060, MUL, 1, 0, 1, acc);
        in_valid = 0;
        @(negedge clock);
        check("mul_ill_m0", ill0, 1'b1);
        check("mul_wen_m0", wen0, 1'b0);
        check("mul_alu_m1", alu1, 6'b100000);
        check("mul_ill_m1", ill1, 1'b0);
        realign();

        // Reset while skid is full
        drive(1, 16'h0070, ADD, 0, 0, 1, acc);
        drive(1, 16'h0074, LW, 0, 0, 1, acc);
        drive(0, 0, 0, 0, 0, 0, acc);
        reset = 1;
        @(negedge clock);
        check("rst_valid", vld0, 1'b0);
        check("rst_release_ready", rdy0, 1'b1);
        realign();

        // Random traffic
        have = 0; cpc = 0; cins = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!have) begin
                cins = $urandom;
                case ($urandom_range(0, 3))
                    0: f7 = 7'h00;
                    1: f7 = 7'h20;
                    2: f7 = 7'h01;
                    default: f7 = 7'($urandom);
                endcase
                cins[31:25] = f7;
                if ($urandom_range(0, 11) < 9) cins[6:0] = ops[$urandom_range(0, 8)];
                else if ($urandom_range(0, 1) == 0) cins[6:0] = 7'h6F;
                cpc = ($urandom_range(0, 3) == 0) ? 16'hFFF0 | 16'($urandom_range(0, 15)) : 16'($urandom);
                have = 1;
            end
            drive($urandom_range(0, 9) < 7, cpc, cins, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 199) >= 2, acc);
            if (acc) have = 0;
        end
        repeat (8) drive(0, 0, 0, 1, 0, 1, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
